fifo_read_ctrl: RTL and testbench

// Read-side controller for the 16x8 FIFO storage. It tracks the entries committed by the

---
 rtl/fifo_read_ctrl.sv | 156 +++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read side of the 16x8 FIFO storage.
// Counts entries committed by the write side, fetches them from the registered
// storage in order, and delivers them on a valid/ready stream through a
// two-entry output buffer. Fetches are credit-limited so that the buffer can
// never receive a capture it has no room for.
module fifo_read_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_pulse,
  output logic [ADDR_W-1:0] read_address,
  output logic              rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  // Output buffer occupancy states
  localparam logic [1:0] BUF_EMPTY = 2'd0;
  localparam logic [1:0] BUF_ONE   = 2'd1;
  localparam logic [1:0] BUF_TWO   = 2'd2;

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEVEL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LEVEL_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]   level_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              inflight_r;
  logic [1:0]        buf_cnt_r;
  logic [1:0]        buf_cnt_nxt_s;
  logic [DATA_W-1:0] buf_head_r;
  logic [DATA_W-1:0] buf_tail_r;
  logic              overflow_r;
  logic              pop_s;
  logic              fetch_s;
  logic              capture_s;
  logic [2:0]        credit_s;

  assign out_valid    = (buf_cnt_r != BUF_EMPTY);
  assign out_data     = buf_head_r;
  assign read_address = rd_ptr_r;
  assign rd_en        = fetch_s;
  assign level        = level_r;
  assign empty        = (level_r == LEVEL_ZERO);
  assign full         = (level_r == LEVEL_FULL);
  assign overflow     = overflow_r;
  assign capture_s    = inflight_r;

  // Fetch decision: entries waiting and room for them once pops are counted
  always_comb begin
    pop_s    = out_valid & out_ready;
    credit_s = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if ((level_r != LEVEL_ZERO) && (credit_s < 3'd2)) begin
      fetch_s = 1'b1;
    end else begin
      fetch_s = 1'b0;
    end
  end

  // Next occupancy of the output buffer from capture/pop
  always_comb begin
    buf_cnt_nxt_s = buf_cnt_r;
    case (buf_cnt_r)
      BUF_EMPTY: begin
        if (capture_s) buf_cnt_nxt_s = BUF_ONE;
        else           buf_cnt_nxt_s = BUF_EMPTY;
      end
      BUF_ONE: begin
        if (capture_s && !pop_s)      buf_cnt_nxt_s = BUF_TWO;
        else if (!capture_s && pop_s) buf_cnt_nxt_s = BUF_EMPTY;
        else                          buf_cnt_nxt_s = BUF_ONE;
      end
      BUF_TWO: begin
        if (pop_s && !capture_s) buf_cnt_nxt_s = BUF_ONE;
        else                     buf_cnt_nxt_s = BUF_TWO;
      end
      default: buf_cnt_nxt_s = BUF_EMPTY;
    endcase
  end

  // Storage-side bookkeeping: level, read pointer, in-flight flag, overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r    <= LEVEL_ZERO;
      rd_ptr_r   <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      inflight_r <= fetch_s;
      if (fetch_s) begin
        // power-of-two depth: natural wrap from DEPTH-1 to 0
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (wr_pulse && !fetch_s) begin
        if (level_r == LEVEL_FULL) begin
          level_r    <= LEVEL_FULL;
          overflow_r <= 1'b1;
        end else begin
          level_r    <= level_r + LEVEL_ONE;
        end
      end else if (!wr_pulse && fetch_s) begin
        level_r <= level_r - LEVEL_ONE;
      end else begin
        level_r <= level_r;
      end
    end
  end

  // Output buffer: head is the oldest entry and drives out_data
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt_r  <= BUF_EMPTY;
      buf_head_r <= {DATA_W{1'b0}};
      buf_tail_r <= {DATA_W{1'b0}};
    end else begin
      buf_cnt_r <= buf_cnt_nxt_s;
      case (buf_cnt_r)
        BUF_EMPTY: begin
          if (capture_s) buf_head_r <= mem_data;
          else           buf_head_r <= buf_head_r;
        end
        BUF_ONE: begin
          if (capture_s && pop_s) buf_head_r <= mem_data;
          else if (capture_s)     buf_tail_r <= mem_data;
          else                    buf_head_r <= buf_head_r;
        end
        BUF_TWO: begin
          // the fetch credit keeps capture out of this state; handled anyway
          if (pop_s) begin
            buf_head_r <= buf_tail_r;
            if (capture_s) buf_tail_r <= mem_data;
            else           buf_tail_r <= buf_tail_r;
          end else begin
            buf_head_r <= buf_head_r;
          end
        end
        default: begin
          buf_head_r <= {DATA_W{1'b0}};
          buf_tail_r <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: registered storage model acting as write side,
// a queue-based reference model compared every cycle, and directed scenarios
// with hand-computed expectations.
module tb_fifo_read_ctrl;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       wr_pulse;
  logic [3:0] read_address;
  logic       rd_en;
  logic [7:0] mem_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;

  fifo_read_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_pulse(wr_pulse), .read_address(read_address),
    .rd_en(rd_en), .mem_data(mem_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level),
    .empty(empty), .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // write-side data and storage
  logic [7:0] wdata;
  logic [7:0] mem [0:15];
  bit         wr_acc;
  int         wr_idx;
  logic [7:0] wr_val;

  always @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= wr_val;
    if (rd_en) mem_data <= mem[read_address];
  end

  // reference model: queues of unfetched, in-flight and buffered entries
  byte unsigned pend[$];
  byte unsigned infl[$];
  byte unsigned obuf[$];
  int  m_rdptr, m_wrptr;
  bit  m_ovf, live;

  always @(negedge clk) begin : model_cmp
    bit e_pop, e_fetch, cap;
    byte unsigned v;
    if (rst) begin
      pend.delete(); infl.delete(); obuf.delete();
      m_rdptr = 0; m_wrptr = 0; m_ovf = 0; live = 1; wr_acc = 0;
    end else if (live) begin
      e_pop   = (obuf.size() != 0) && out_ready;
      e_fetch = (pend.size() != 0) && ((obuf.size() + infl.size() - int'(e_pop)) < 2);
      chk("rd_en", rd_en, e_fetch);
      chk("read_address", read_address, m_rdptr);
      chk("level", level, pend.size());
      chk("empty", empty, pend.size() == 0);
      chk("full", full, pend.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("out_valid", out_valid, obuf.size() != 0);
      if (obuf.size() != 0) chk("out_data", out_data, obuf[0]);
      wr_acc = wr_pulse && !(pend.size() == DEPTH && !e_fetch);
      wr_idx = m_wrptr;
      wr_val = wdata;
      if (wr_pulse && pend.size() == DEPTH && !e_fetch) m_ovf = 1;
      cap = (infl.size() != 0);
      if (cap) v = infl.pop_front();
      if (e_pop) void'(obuf.pop_front());
      if (cap) obuf.push_back(v);
      if (e_fetch) begin
        infl.push_back(pend.pop_front());
        m_rdptr = (m_rdptr + 1) % DEPTH;
      end
      if (wr_acc) begin
        pend.push_back(wdata);
        m_wrptr = (m_wrptr + 1) % DEPTH;
      end
    end else begin
      wr_acc = 0;
    end
  end

  // per-step samples for the directed literal checks
  logic       s_valid, s_rd_en, s_ovf, s_full, s_empty;
  logic [7:0] s_data;
  logic [4:0] s_level;
  logic [3:0] s_addr;
  byte unsigned popped[$];
  int addr_log[$];

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    wr_pulse = w; wdata = d; out_ready = r; rst = rs;
    @(negedge clk);
    s_valid = out_valid; s_data = out_data; s_level = level; s_rd_en = rd_en;
    s_addr = read_address; s_ovf = overflow; s_full = full; s_empty = empty;
    if (s_valid && r && !rs) popped.push_back(s_data);
    if (s_rd_en && !rs) addr_log.push_back(int'(s_addr));
    @(posedge clk);
    #1;
  endtask

  byte unsigned t1 [3] = '{8'h11, 8'h22, 8'h33};
  byte unsigned t2 [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
  int first_valid;
  int fetches;

  initial begin
    rst = 1'b1; wr_pulse = 1'b0; out_ready = 1'b0; wdata = 8'h00;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // reset state
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_level", s_level, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_rd_en", s_rd_en, 0);

    // 1: latency and streaming
    popped.delete(); first_valid = -1;
    for (int i = 0; i < 9; i++) begin
      step(i < 3, (i < 3) ? t1[i] : 8'h00, 1'b1, 1'b0);
      if (s_valid && first_valid < 0) first_valid = i;
    end
    chk("t1_first_valid_cycle", first_valid, 3);
    chk("t1_count", popped.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t1_data", (i < popped.size()) ? popped[i] : 32'hDEAD, t1[i]);
    chk("t1_empty", s_empty, 1);

    // 2: backpressure
    step(1'b0, 8'h00, 1'b0, 1'b1);
    popped.delete(); addr_log.delete();
    for (int i = 0; i < 8; i++) step(i < 4, (i < 4) ? t2[i] : 8'h00, 1'b0, 1'b0);
    chk("t2_fetches", addr_log.size(), 2);
    chk("t2_level", s_level, 2);
    chk("t2_valid", s_valid, 1);
    chk("t2_held_data", s_data, 8'hA1);
    chk("t2_rd_en_idle", s_rd_en, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_count", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_data", (i < popped.size()) ? popped[i] : 32'hDEAD, t2[i]);

    // 3: pointer wrap with interleaved backpressure
    step(1'b0, 8'h00, 1'b0, 1'b1);
    popped.delete(); addr_log.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), (i % 3) != 2, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_count", popped.size(), 20);
    for (int i = 0; i < 20; i++)
      chk("t3_data", (i < popped.size()) ? popped[i] : 32'hDEAD, 8'h40 + i);
    chk("t3_addr15", (addr_log.size() > 16) ? addr_log[15] : -1, 15);
    chk("t3_addr_wrap", (addr_log.size() > 16) ? addr_log[16] : -1, 0);

    // 4: full and overflow
    step(1'b0, 8'h00, 1'b0, 1'b1);
    popped.delete();
    for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_full", s_full, 1);
    chk("t4_level_full", s_level, 16);
    chk("t4_no_ovf", s_ovf, 0);
    step(1'b1, 8'h9F, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_wr_fetch_level", s_level, 16);
    chk("t4_wr_fetch_ovf", s_ovf, 0);
    chk("t4_popped_first", (popped.size() > 0) ? popped[0] : 32'hDEAD, 8'h80);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_ovf", s_ovf, 1);
    chk("t4_ovf_level", s_level, 16);

    // 5: reset while a fetch is in flight and the buffer is full
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(i < 4, 8'(8'h51 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_pre_rd_en", s_rd_en, 1);
    chk("t5_pre_valid", s_valid, 1);
    chk("t5_pre_level", s_level, 2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_valid", s_valid, 0);
    chk("t5_level", s_level, 0);
    chk("t5_addr", s_addr, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_no_capture", s_valid, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
